// File: rtl/regfile_pkg.sv
// Shared constants and types for the CPU register file.
// Imported by the storage top and its read ports.
package regfile_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One handshaked register-file read port.
// One-entry output buffer, x0 forcing and write bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [WIDTH-1:0]  wrdata,
  input  logic [WIDTH-1:0]  rd_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data
);

  logic             accept;
  logic             is_zero;
  logic             bypass;
  logic [WIDTH-1:0] value;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign is_zero   = req_addr == ADDR_W'(ZERO_REG);
  assign bypass    = wrenable && (wraddr == req_addr)
                   && !is_zero;

  always_comb begin
    value = rd_data;
    unique case (1'b1)
      is_zero: value = '0;
      bypass:  value = wrdata;
      default: value = rd_data;
    endcase
  end

  // Data is captured at accept so later writes cannot disturb a held response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= value;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_read_unit.sv
// Register file storage with one write port and
// two independent handshaked read ports (a = rs, b = rt).
module regfile_read_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [WIDTH-1:0]  wrdata,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [WIDTH-1:0]  a_resp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_req_addr,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [WIDTH-1:0]  b_resp_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_rd;
  logic [WIDTH-1:0] b_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrenable && wraddr != ADDR_W'(ZERO_REG)) begin
      mem[wraddr] <= wrdata;
    end
  end

  assign a_rd = mem[a_req_addr];
  assign b_rd = mem[b_req_addr];

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrenable   (wrenable),
    .wraddr     (wraddr),
    .wrdata     (wrdata),
    .rd_data    (a_rd),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_addr   (a_req_addr),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_data  (a_resp_data)
  );

  regfile_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_port_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrenable   (wrenable),
    .wraddr     (wraddr),
    .wrdata     (wrdata),
    .rd_data    (b_rd),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_addr   (b_req_addr),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_data  (b_resp_data)
  );

endmodule

// File: doc/regfile_read_unit.md
# regfile_read_unit

Dual-port read side of the CPU register file: 32 × 32-bit storage with one write port and two independent, handshaked read ports (rs and rt). Each read port accepts an address with a valid/ready handshake and returns the data one cycle later through a one-entry output buffer that holds under back-pressure. Register 0 always reads as zero. Same-cycle write data is bypassed to an accepted read. Sits between instruction decode and the ALU operand latches.

## Interface
Parameters:
- WIDTH, 32, data width of every register
- DEPTH, 32, number of registers
- ADDR_W, 5, address width; must satisfy 2**ADDR_W == DEPTH

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- wrenable  in  1  write strobe
- wraddr  in  ADDR_W  write address
- wrdata  in  WIDTH  write data
- a_req_valid  in  1  port A read request valid
- a_req_ready  out  1  port A can accept a request
- a_req_addr  in  ADDR_W  port A read address
- a_resp_valid  out  1  port A response valid
- a_resp_ready  in  1  port A consumer accepts response
- a_resp_data  out  WIDTH  port A read data
- b_* : identical set for port B

## Operation
- Reset (rst_n low at a rising edge): all DEPTH registers cleared to 0; a_resp_valid and b_resp_valid = 0; a_resp_data and b_resp_data = 0. Reset overrides any write or request in the same cycle.
- Write: when wrenable = 1 and wraddr != 0, reg[wraddr] <= wrdata. A write to address 0 is ignored; reg[0] stays 0.
- Request acceptance per port: accept = req_valid & req_ready. req_ready = !resp_valid | resp_ready (combinational, pipelined fill/drain).
- On accept: resp_data <= value(addr), resp_valid <= 1, where value(addr) = 0 if addr == 0; else wrdata if wrenable & wraddr == addr (write bypass); else reg[addr].
- On resp_valid & resp_ready without a new accept: resp_valid <= 0; resp_data holds its last value.
- Held response (resp_valid & !resp_ready): resp_data is a snapshot taken at accept. Later writes to that address do not alter it.
- Ports A and B are fully independent; both may read the same address in the same cycle and both see the same value, including the bypass.
- Address range: every address < DEPTH is valid; no out-of-range handling is needed.

## Timing
- Read latency: 1 cycle from accept to resp_valid.
- Throughput: 1 read per cycle per port while resp_ready stays high.
- Write-to-read: a write in cycle N is visible to a read accepted in cycle N (via bypass) or later (via storage).
- req_ready depends combinationally on resp_ready only. resp_valid and resp_data are registered outputs.
- No combinational path from req_addr or wrdata to any output.

## Structure
- Shared package regfile_pkg holds:
  - REG_WIDTH = 32, REG_DEPTH = 32, REG_ADDR_W = 5
  - ZERO_REG = 0
  - the typedef for the register word
- Natural sub-module: regfile_read_port. It contains the handshake, output buffer, zero-register check and bypass mux. Instantiate it twice; it sees the storage array read data plus the write-port signals.
- Storage array and write logic live in the top module.

## Test plan
- Reset then read: assert rst_n = 0 for 1 cycle; read addresses 0, 7 and 31 on port A → resp_data = 0 for each; resp_valid = 0 during reset.
- Write and read back: write 0xDEADBEEF to reg 5; next cycle read reg 5 on both ports → both return 0xDEADBEEF one cycle after accept.
- Zero register: write 0x12345678 to reg 0, then read reg 0 → 0x00000000. Same-cycle write+read of reg 0 also returns 0.
- Bypass: in the same cycle, write 0xA5A5A5A5 to reg 9 and accept a port B read of reg 9 (reg 9 previously 0x1) → b_resp_data = 0xA5A5A5A5.
- Back-pressure: accept a read of reg 3 (value 0x33); hold a_resp_ready = 0 for 3 cycles while writing 0x44 to reg 3 → a_req_ready = 0, a_resp_data stays 0x33, resp_valid stays 1. Raise resp_ready with a new request for reg 3 → next response 0x44. Checks back-to-back streaming with no bubble.
- Reset mid-operation: with a_resp_valid = 1 and stalled, pull rst_n low → next cycle a_resp_valid = 0, a_resp_data = 0, and reg 3 reads 0.
